fb_scanout: RTL
===============

Name: fb_scanout

Overview:
- Downstream stage of the tile/sprite renderer.
- Consumes the renderer's pixel-write strobes (h, v, RGB332, done) and its end-of-frame pulse.
- Writes the pixels into the back half of an external double-buffered frame RAM.
- Scans the front half out with its own video timing. Buffers swap only at vblank, so the display never tears.

Parameters:
- H_TOTAL, 384: pixel clocks per line.
- H_ACTIVE, 256: visible pixels per line.
- H_SYNC_START, 296: first hsync pixel.
- H_SYNC_END, 328: first pixel after hsync.
- V_TOTAL, 264: lines per frame.
- V_ACTIVE, 224: visible lines.
- V_SYNC_START, 240: first vsync line.
- V_SYNC_END, 243: first line after vsync.
- V_OFFSET, 16: framebuffer row shown on visible line 0.

Ports:
- clk  in  1: system clock.
- reset  in  1: synchronous, active-high.
- ce_pix  in  1: pixel clock enable; asserted at most every 2nd clk.
- pix_we  in  1: renderer pixel strobe (the renderer's done).
- pix_h  in  8: pixel column.
- pix_v  in  8: pixel row.
- pix_rgb  in  8: {b[1:0], g[2:0], r[2:0]}.
- frame_done  in  1: renderer end-of-frame pulse.
- fb_we  out  1: RAM write enable.
- fb_waddr  out  17: {buf, v, h}.
- fb_wdata  out  8: RAM write data.
- fb_raddr  out  17: {buf, row, col}.
- fb_rdata  in  8: RAM read data, valid 1 clk after fb_raddr.
- video_r  out  3: red.
- video_g  out  3: green.
- video_b  out  2: blue.
- hsync  out  1: active-high.
- vsync  out  1: active-high.
- hblank  out  1: horizontal blank.
- vblank  out  1: vertical blank.
- front_buf  out  1: index of the buffer being displayed.

Behaviour:
- Reset:
  - Outputs: all outputs 0, including front_buf=0.
  - Internal state: hc=vc=0, swap_pending=0, pipeline registers 0.
- Write path (every clk, independent of ce_pix):
  - fb_we <= pix_we, fb_waddr <= {~front_buf, pix_v, pix_h}, fb_wdata <= pix_rgb. Latency is 1 clk.
  - Every write is forwarded; nothing is dropped or merged.
- Swap:
  - frame_done sets swap_pending.
  - On the ce_pix where hc==H_ACTIVE and vc==V_ACTIVE-1 (start of the first vblank line), if swap_pending: front_buf toggles and swap_pending clears.
  - frame_done on that same clk swaps immediately.
  - A pix_we on the same clk as frame_done goes to the old back buffer.
  - A second frame_done before the swap is absorbed; at most one toggle per frame.
- Timing counters advance only on ce_pix:
  - hc wraps H_TOTAL-1 -> 0; vc increments on hc wrap and wraps V_TOTAL-1 -> 0.
  - hblank_n = hc>=H_ACTIVE; vblank_n = vc>=V_ACTIVE.
  - hsync_n = H_SYNC_START<=hc<H_SYNC_END; vsync_n = V_SYNC_START<=vc<V_SYNC_END.
- Read pipeline:
  - Stage 0 (ce_pix): fb_raddr <= {front_buf, (vc+V_OFFSET)[7:0], hc[7:0]}; the four timing bits are latched into a delay register.
  - Stage 1 (next ce_pix): video_* <= fb_rdata fields, or 0 if either delayed blank is set; hsync/vsync/hblank/vblank <= delayed bits.
  - All outputs lag the counters by exactly one pixel and stay mutually aligned.
  - Row arithmetic is 8-bit and wraps.
- State machines:
  - Swap FSM: IDLE -> PENDING (frame_done), PENDING -> IDLE (vblank-start swap).
  - Scan: free-running counters.
- Reset mid-frame: counters return to 0 and the swap request is lost; the next frame_done re-arms it.

Optional Feature:
- Macro FB_SCANLINE_EN.
- Defined: on visible lines with delayed vc odd, each colour component is shifted right by 1 (r>>1, g>>1, b>>1).
- Undefined: output is unmodified. No ports change in either case.

Decomposition:
- Package fb_pkg holds:
  - the timing constants as defaults;
  - FB_AW=17;
  - an rgb332 struct {b[1:0], g[2:0], r[2:0]};
  - the swap FSM state enum.
- Sub-module fb_video_timing: hc/vc counters plus sync/blank generation, gated by ce_pix.
- fb_scanout instantiates fb_video_timing and implements the write path, swap FSM and read pipeline.

Test Plan:
- Reset, then pix_we=1, h=0x12, v=0x34, rgb=0xA5 -> next clk: fb_we=1, fb_waddr=0x13412, fb_wdata=0xA5.
- frame_done pulse at vc=100 -> front_buf stays 0 until vc=223/hc=256 ce_pix, then 1; the next write addresses buffer 0.
- frame_done on the exact vblank-start clk -> swap happens that ce_pix; a coincident pix_we uses the old back buffer (bit16=1).
- ce_pix every 2 clk, RAM model returning addr[7:0] -> video_r/g/b at (hc=5, vc=0) decode 0x05 one pixel late; row read = 16; outputs 0 while blanked.
- Count ce_pix per hsync period = 384 and lines per vsync = 264; hsync width 32 px, vsync width 3 lines.
- FB_SCANLINE_EN defined, fb_rdata=0xFF -> line 1 outputs r=3, g=3, b=1; line 0 outputs 7, 7, 3.

Source files
------------

// File: rtl/fb_scanout_pkg.sv
// fb_pkg: shared definitions for the frame-buffer scan-out block.
//   - default video timing constants (overridable per instance)
//   - frame RAM address width and counter width
//   - rgb332_t pixel layout and the buffer-swap FSM state type
//   - rgb_dim(): halves each colour component (scanline darkening)
package fb_pkg;

    localparam int unsigned DEF_H_TOTAL      = 384;
    localparam int unsigned DEF_H_ACTIVE     = 256;
    localparam int unsigned DEF_H_SYNC_START = 296;
    localparam int unsigned DEF_H_SYNC_END   = 328;
    localparam int unsigned DEF_V_TOTAL      = 264;
    localparam int unsigned DEF_V_ACTIVE     = 224;
    localparam int unsigned DEF_V_SYNC_START = 240;
    localparam int unsigned DEF_V_SYNC_END   = 243;
    localparam int unsigned DEF_V_OFFSET     = 16;

    localparam int unsigned FB_AW = 17;
    localparam int unsigned CNT_W = 9;

    typedef struct packed {
        logic [1:0] b;
        logic [2:0] g;
        logic [2:0] r;
    } rgb332_t;

    typedef enum logic {
        SWAP_IDLE,
        SWAP_PENDING
    } swap_state_t;

    function automatic rgb332_t rgb_dim(input rgb332_t c);
        rgb332_t d;
        d.b = c.b >> 1;
        d.g = c.g >> 1;
        d.r = c.r >> 1;
        return d;
    endfunction

endpackage

// File: rtl/fb_scanout_if.sv
// fb_scanout_if: bus between the scan-out block and the external
// double-buffered frame RAM.
//   fb_we / fb_waddr / fb_wdata : write port ({buf, v, h})
//   fb_raddr / fb_rdata         : read port, data valid 1 clk after address
// Modports: master = scan-out block, slave = RAM.
interface fb_scanout_if;
    import fb_pkg::*;

    logic             fb_we;
    logic [FB_AW-1:0] fb_waddr;
    logic [7:0]       fb_wdata;
    logic [FB_AW-1:0] fb_raddr;
    logic [7:0]       fb_rdata;

    modport master (
        output fb_we, fb_waddr, fb_wdata, fb_raddr,
        input  fb_rdata
    );

    modport slave (
        input  fb_we, fb_waddr, fb_wdata, fb_raddr,
        output fb_rdata
    );

endinterface

// File: rtl/fb_video_timing.sv
// fb_video_timing: free-running horizontal/vertical pixel counters with
// sync and blank decode, advancing only on ce_pix.
//   clk, reset (sync, active-high), ce_pix : clocking
//   hc, vc                                 : current pixel position
//   hsync, vsync, hblank, vblank           : decoded from hc/vc (undelayed)
module fb_video_timing
    import fb_pkg::*;
#(
    parameter int unsigned H_TOTAL      = DEF_H_TOTAL,
    parameter int unsigned H_ACTIVE     = DEF_H_ACTIVE,
    parameter int unsigned H_SYNC_START = DEF_H_SYNC_START,
    parameter int unsigned H_SYNC_END   = DEF_H_SYNC_END,
    parameter int unsigned V_TOTAL      = DEF_V_TOTAL,
    parameter int unsigned V_ACTIVE     = DEF_V_ACTIVE,
    parameter int unsigned V_SYNC_START = DEF_V_SYNC_START,
    parameter int unsigned V_SYNC_END   = DEF_V_SYNC_END
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ce_pix,
    output logic [CNT_W-1:0] hc,
    output logic [CNT_W-1:0] vc,
    output logic             hsync,
    output logic             vsync,
    output logic             hblank,
    output logic             vblank
);

    always_ff @(posedge clk) begin
        if (reset) begin
            hc <= '0;
            vc <= '0;
        end else if (ce_pix) begin
            if (hc == CNT_W'(H_TOTAL - 1)) begin
                hc <= '0;
                if (vc == CNT_W'(V_TOTAL - 1)) begin
                    vc <= '0;
                end else begin
                    vc <= vc + 1'b1;
                end
            end else begin
                hc <= hc + 1'b1;
            end
        end
    end

    always_comb begin
        hblank = (hc >= CNT_W'(H_ACTIVE));
        vblank = (vc >= CNT_W'(V_ACTIVE));
        hsync  = (hc >= CNT_W'(H_SYNC_START)) && (hc < CNT_W'(H_SYNC_END));
        vsync  = (vc >= CNT_W'(V_SYNC_START)) && (vc < CNT_W'(V_SYNC_END));
    end

endmodule

// File: rtl/fb_scanout.sv
// fb_scanout: writes renderer pixels into the back half of a double-buffered
// frame RAM and scans the front half out with its own video timing. The
// buffers swap only at the start of vblank, so the display never tears.
//   clk, reset (sync, active-high), ce_pix (at most every 2nd clk)
//   pix_we, pix_h, pix_v, pix_rgb : renderer pixel strobe and data
//   frame_done                    : renderer end-of-frame pulse
//   fb                            : frame RAM bus (fb_scanout_if.master)
//   video_r/g/b, hsync, vsync, hblank, vblank : video out, one pixel late
//   front_buf                     : buffer currently displayed
// Build option: define FB_SCANLINE_EN to halve every colour component on
// odd visible lines.
module fb_scanout
    import fb_pkg::*;
#(
    parameter int unsigned H_TOTAL      = DEF_H_TOTAL,
    parameter int unsigned H_ACTIVE     = DEF_H_ACTIVE,
    parameter int unsigned H_SYNC_START = DEF_H_SYNC_START,
    parameter int unsigned H_SYNC_END   = DEF_H_SYNC_END,
    parameter int unsigned V_TOTAL      = DEF_V_TOTAL,
    parameter int unsigned V_ACTIVE     = DEF_V_ACTIVE,
    parameter int unsigned V_SYNC_START = DEF_V_SYNC_START,
    parameter int unsigned V_SYNC_END   = DEF_V_SYNC_END,
    parameter int unsigned V_OFFSET     = DEF_V_OFFSET
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce_pix,
    input  logic       pix_we,
    input  logic [7:0] pix_h,
    input  logic [7:0] pix_v,
    input  logic [7:0] pix_rgb,
    input  logic       frame_done,
    fb_scanout_if.master fb,
    output logic [2:0] video_r,
    output logic [2:0] video_g,
    output logic [1:0] video_b,
    output logic       hsync,
    output logic       vsync,
    output logic       hblank,
    output logic       vblank,
    output logic       front_buf
);

    logic [CNT_W-1:0] hc;
    logic [CNT_W-1:0] vc;
    logic             t_hsync;
    logic             t_vsync;
    logic             t_hblank;
    logic             t_vblank;

    fb_video_timing #(
        .H_TOTAL      (H_TOTAL),
        .H_ACTIVE     (H_ACTIVE),
        .H_SYNC_START (H_SYNC_START),
        .H_SYNC_END   (H_SYNC_END),
        .V_TOTAL      (V_TOTAL),
        .V_ACTIVE     (V_ACTIVE),
        .V_SYNC_START (V_SYNC_START),
        .V_SYNC_END   (V_SYNC_END)
    ) u_timing (
        .clk    (clk),
        .reset  (reset),
        .ce_pix (ce_pix),
        .hc     (hc),
        .vc     (vc),
        .hsync  (t_hsync),
        .vsync  (t_vsync),
        .hblank (t_hblank),
        .vblank (t_vblank)
    );

    // Write path: registered pass-through into the current back buffer.
    // front_buf is sampled before any same-clk swap takes effect.
    always_ff @(posedge clk) begin
        if (reset) begin
            fb.fb_we    <= 1'b0;
            fb.fb_waddr <= '0;
            fb.fb_wdata <= '0;
        end else begin
            fb.fb_we    <= pix_we;
            fb.fb_waddr <= {~front_buf, pix_v, pix_h};
            fb.fb_wdata <= pix_rgb;
        end
    end

    // Swap FSM
    swap_state_t state;
    swap_state_t state_next;
    logic        vblank_start;
    logic        swap;

    always_comb begin
        state_next   = state;
        swap         = 1'b0;
        vblank_start = ce_pix && (hc == CNT_W'(H_ACTIVE))
                              && (vc == CNT_W'(V_ACTIVE - 1));
        case (state)
            SWAP_IDLE: begin
                // a frame_done landing on the vblank-start pixel swaps at once
                if (frame_done && vblank_start) begin
                    swap = 1'b1;
                end else if (frame_done) begin
                    state_next = SWAP_PENDING;
                end
            end
            SWAP_PENDING: begin
                if (vblank_start) begin
                    swap       = 1'b1;
                    state_next = SWAP_IDLE;
                end
            end
            default: state_next = SWAP_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SWAP_IDLE;
            front_buf <= 1'b0;
        end else begin
            state <= state_next;
            if (swap) begin
                front_buf <= ~front_buf;
            end
        end
    end

    // Read pipeline: stage 0 issues the RAM address and delays the timing
    // bits; stage 1 (next pixel) takes RAM data and the delayed bits together.
    logic [7:0] row;
    logic       d_hsync;
    logic       d_vsync;
    logic       d_hblank;
    logic       d_vblank;
    rgb332_t    pix;

    assign row = vc[7:0] + 8'(V_OFFSET);

`ifdef FB_SCANLINE_EN
    logic d_vodd;

    always_ff @(posedge clk) begin
        if (reset) begin
            d_vodd <= 1'b0;
        end else if (ce_pix) begin
            d_vodd <= vc[0];
        end
    end
`endif

    always_comb begin
        pix = rgb332_t'(fb.fb_rdata);
`ifdef FB_SCANLINE_EN
        if (d_vodd) begin
            pix = rgb_dim(pix);
        end
`endif
        if (d_hblank || d_vblank) begin
            pix = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fb.fb_raddr <= '0;
            d_hsync     <= 1'b0;
            d_vsync     <= 1'b0;
            d_hblank    <= 1'b0;
            d_vblank    <= 1'b0;
            video_r     <= '0;
            video_g     <= '0;
            video_b     <= '0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
            hblank      <= 1'b0;
            vblank      <= 1'b0;
        end else if (ce_pix) begin
            fb.fb_raddr <= {front_buf, row, hc[7:0]};
            d_hsync     <= t_hsync;
            d_vsync     <= t_vsync;
            d_hblank    <= t_hblank;
            d_vblank    <= t_vblank;
            video_r     <= pix.r;
            video_g     <= pix.g;
            video_b     <= pix.b;
            hsync       <= d_hsync;
            vsync       <= d_vsync;
            hblank      <= d_hblank;
            vblank      <= d_vblank;
        end
    end

endmodule
